// File: rtl/request_unit_pkg.sv
// rtl/request_unit_pkg.sv - shared types and helpers for the request sequencer
package request_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM,
    HALT
  } reqstate_t;

  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/request_unit_wait_timer.sv
// rtl/request_unit_wait_timer.sv - saturating wait counter with expiry flag
module request_unit_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [W-1:0] MAX = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == MAX);

endmodule

// File: rtl/request_unit.sv
// rtl/request_unit.sv - PC owner and fetch/data request sequencer for a single-cycle CPU
module request_unit
  import request_unit_pkg::*;
#(
  parameter word_t PC_INIT    = 32'h0000_0000,
  parameter int    WAIT_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        dhit,
  input  logic        mem_read_req,
  input  logic        mem_write_req,
  input  logic        halt_req,
  input  logic [31:0] pc_next,
  output logic        iREN,
  output logic [31:0] imemaddr,
  output logic        dREN,
  output logic        dWEN,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        halt,
  output logic        stall_timeout
);

  reqstate_t state_q, state_d;
  word_t     pc_q, pc_d;
  word_t     instr_q, instr_d;
  logic      rd_q, rd_d;
  logic      wr_q, wr_d;
  logic      stall_q, stall_d;
  logic      wait_clr;
  logic      wait_inc;
  logic      wait_expired;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (ihit) begin
          instr_d = imemload;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // halt beats load beats store; a simultaneous store request is dropped
        if (halt_req) begin
          state_d = HALT;
        end else if (mem_read_req) begin
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          state_d = MEM;
        end else if (mem_write_req) begin
          rd_d    = 1'b0;
          wr_d    = 1'b1;
          state_d = MEM;
        end else begin
          pc_d    = word_align(pc_next);
          state_d = FETCH;
        end
      end
      MEM: begin
        if (dhit) begin
          pc_d    = word_align(pc_next);
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = FETCH;
        end
      end
      HALT: state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  assign wait_clr = (state_d != state_q);
  assign wait_inc = ((state_q == FETCH) && !ihit) || ((state_q == MEM) && !dhit);
  assign stall_d  = stall_q | wait_expired;

  request_unit_wait_timer #(
    .LIMIT(WAIT_LIMIT)
  ) u_wait_timer (
    .clk    (CLK),
    .rst_n  (nRST),
    .clr    (wait_clr),
    .inc    (wait_inc),
    .expired(wait_expired)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      stall_q <= stall_d;
    end
  end

  // All outputs come from registered state so no hit input reaches an enable combinationally
  assign iREN          = (state_q == FETCH);
  assign dREN          = (state_q == MEM) && rd_q;
  assign dWEN          = (state_q == MEM) && wr_q;
  assign imemaddr      = pc_q;
  assign instruction   = instr_q;
  assign instr_valid   = (state_q == DECODE) || (state_q == MEM);
  assign halt          = (state_q == HALT);
  assign stall_timeout = stall_q | wait_expired;

endmodule

// File: tb/tb_request_unit.sv
// tb/tb_request_unit.sv - scoreboard bench for request_unit
module tb_request_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] imemload;
  logic        dhit;
  logic        mem_read_req;
  logic        mem_write_req;
  logic        halt_req;
  logic [31:0] pc_next;
  logic        iREN;
  logic [31:0] imemaddr;
  logic        dREN;
  logic        dWEN;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        halt;
  logic        stall_timeout;

  always #5 CLK = ~CLK;

  request_unit #(
    .PC_INIT   (32'h0000_0000),
    .WAIT_LIMIT(4)
  ) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ihit         (ihit),
    .imemload     (imemload),
    .dhit         (dhit),
    .mem_read_req (mem_read_req),
    .mem_write_req(mem_write_req),
    .halt_req     (halt_req),
    .pc_next      (pc_next),
    .iREN         (iREN),
    .imemaddr     (imemaddr),
    .dREN         (dREN),
    .dWEN         (dWEN),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .halt         (halt),
    .stall_timeout(stall_timeout)
  );

  // flag order: {iREN, dREN, dWEN, instr_valid, halt, stall_timeout}
  localparam logic [5:0] F_IDLE  = 6'b000000;
  localparam logic [5:0] F_FETCH = 6'b100000;
  localparam logic [5:0] F_DEC   = 6'b000100;
  localparam logic [5:0] F_RD    = 6'b010100;
  localparam logic [5:0] F_WR    = 6'b001100;
  localparam logic [5:0] F_HALT  = 6'b000010;
  localparam logic [5:0] F_ST    = 6'b000001;

  localparam logic [31:0] I1 = 32'h2001_0001;
  localparam logic [31:0] I2 = 32'h2002_0002;
  localparam logic [31:0] IL = 32'h8C22_0004;
  localparam logic [31:0] I3 = 32'hAC01_0008;
  localparam logic [31:0] I4 = 32'hAC22_0000;
  localparam logic [31:0] I5 = 32'h0000_0020;
  localparam logic [31:0] I6 = 32'h0800_0000;
  localparam logic [31:0] I7 = 32'hFC00_0000;
  localparam logic [31:0] I8 = 32'h8C01_0000;
  localparam logic [31:0] I9 = 32'h3C05_00FF;

  typedef struct {
    int          id;
    logic [5:0]  fl;
    logic [31:0] addr;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;

  function automatic void chk(input int id, input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL step%0d %s got=%h exp=%h", id, nm, act, exp);
    end
  endfunction

  always @(negedge CLK) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.id, "flags{iren,dren,dwen,iv,halt,st}",
          {26'd0, iREN, dREN, dWEN, instr_valid, halt, stall_timeout}, {26'd0, mon_e.fl});
      chk(mon_e.id, "imemaddr", imemaddr, mon_e.addr);
      chk(mon_e.id, "instruction", instruction, mon_e.instr);
    end
  end

  task automatic step(input logic ih, input logic [31:0] im, input logic dh, input logic rd,
                      input logic wr, input logic hl, input logic [31:0] pcn,
                      input logic [5:0] fl, input logic [31:0] ea, input logic [31:0] ei);
    ihit          = ih;
    imemload      = im;
    dhit          = dh;
    mem_read_req  = rd;
    mem_write_req = wr;
    halt_req      = hl;
    pc_next       = pcn;
    step_id++;
    sb.push_back('{step_id, fl, ea, ei});
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    {ihit, dhit, mem_read_req, mem_write_req, halt_req} = '0;
    imemload = '0;
    pc_next  = '0;
    @(posedge CLK);
    #1;
    // reset dominates even with hits present
    step(1, 32'hDEAD_BEEF, 1, 1, 0, 0, 4, F_IDLE, 0, 0);
    step(1, 32'hDEAD_BEEF, 1, 1, 0, 0, 4, F_IDLE, 0, 0);
    nRST = 1'b1;

    // sequential fetch, two cycles per instruction; stray ihit/dhit ignored
    step(1, 32'hDEAD_BEEF, 0, 0, 0, 0, 4, F_IDLE,  0, 0);
    step(1, I1,            1, 0, 0, 0, 4, F_FETCH, 0, 0);
    step(1, 32'hBAD0_0001, 0, 0, 0, 0, 4, F_DEC,   0, I1);
    step(1, I2,            0, 0, 0, 0, 8, F_FETCH, 4, I1);
    step(1, 32'hBAD0_0002, 0, 0, 0, 0, 8, F_DEC,   4, I2);

    // fetch waits three cycles, latches only on hit
    step(0, IL, 0, 0, 0, 0, 8, F_FETCH, 8, I2);
    step(0, IL, 0, 0, 0, 0, 8, F_FETCH, 8, I2);
    step(0, IL, 0, 0, 0, 0, 8, F_FETCH, 8, I2);
    step(1, IL, 0, 0, 0, 0, 8, F_FETCH, 8, I2);

    // load with dhit on the third MEM cycle
    step(0, 0, 0, 1, 0, 0, 12, F_DEC, 8, IL);
    step(1, 32'h1111_1111, 0, 0, 0, 0, 12, F_RD, 8, IL);
    step(0, 0, 0, 0, 0, 0, 12, F_RD, 8, IL);
    step(0, 0, 1, 0, 0, 0, 12, F_RD, 8, IL);
    step(1, I3, 1, 0, 0, 0, 0, F_FETCH, 12, IL);

    // read and write both requested: read wins; misaligned target aligned
    step(0, 0, 0, 1, 1, 0, 32'h13, F_DEC, 12, I3);
    step(0, 0, 1, 0, 0, 0, 32'h13, F_RD,  12, I3);
    step(1, I4, 0, 0, 0, 0, 0,     F_FETCH, 32'h10, I3);

    // store
    step(0, 0, 0, 0, 1, 0, 32'h16, F_DEC, 32'h10, I4);
    step(0, 0, 1, 0, 0, 0, 32'h16, F_WR,  32'h10, I4);
    step(1, I5, 0, 0, 0, 0, 0,     F_FETCH, 32'h14, I4);

    // PC wrap through the top of the address space
    step(0, 0,  0, 0, 0, 0, 32'hFFFF_FFFF, F_DEC,   32'h14, I5);
    step(1, I6, 0, 0, 0, 0, 0,             F_FETCH, 32'hFFFF_FFFC, I5);
    step(0, 0,  0, 0, 0, 0, 0,             F_DEC,   32'hFFFF_FFFC, I6);
    step(1, I7, 0, 0, 0, 0, 0,             F_FETCH, 0, I6);

    // halt beats a load request and is terminal
    step(0, 0, 0, 1, 0, 1, 4, F_DEC, 0, I7);
    for (int i = 0; i < 10; i++) begin
      step(i[0], 32'h1234_0000 + i, ~i[0], 1, 1, 0, 8, F_HALT, 0, I7);
    end
    nRST = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, F_IDLE, 0, 0);
    nRST = 1'b1;

    // reset mid-MEM drops dREN without a clock edge
    step(1, I8, 0, 0, 0, 0, 4, F_IDLE,  0, 0);
    step(1, I8, 0, 0, 0, 0, 4, F_FETCH, 0, 0);
    step(0, 0,  0, 1, 0, 0, 4, F_DEC,   0, I8);
    step(0, 0,  0, 0, 0, 0, 4, F_RD,    0, I8);
    nRST = 1'b0;
    step(0, 0, 0, 0, 0, 0, 4, F_IDLE, 0, 0);
    step(0, 0, 1, 0, 0, 0, 4, F_IDLE, 0, 0);
    nRST = 1'b1;

    // wait limit of 4: set after the fourth miss, sticky afterwards
    step(0, I9, 0, 0, 0, 0, 4, F_IDLE, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      step(0, I9, 0, 0, 0, 0, 4, (i >= 5) ? (F_FETCH | F_ST) : F_FETCH, 0, 0);
    end
    step(1, I9, 0, 0, 0, 0, 4, F_FETCH | F_ST, 0, 0);
    step(0, 0,  0, 0, 0, 0, 4, F_DEC | F_ST,   0, I9);
    step(0, 0,  0, 0, 0, 0, 4, F_FETCH | F_ST, 4, I9);

    @(negedge CLK);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
